// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-neuron datapath.
package snn_pkg;

   localparam int unsigned VMEM_W = 16;
   localparam int unsigned CNT_W  = 8;

   localparam logic [VMEM_W-1:0] VMEM_MAX = 16'hFFFF;

   typedef enum logic {
      INTEG  = 1'b0,
      REFRAC = 1'b1
   } lif_state_e;

   // Increment that sticks at the top of the range.
   function automatic logic [VMEM_W-1:0] sat_inc(input logic [VMEM_W-1:0] x);
      return (x == VMEM_MAX) ? x : x + VMEM_W'(1);
   endfunction

endpackage

// File: rtl/lif_leak_sat.sv
// Membrane update: subtract the shift-based leak, add the gated input, clamp at full scale.
module lif_leak_sat
   import snn_pkg::*;
#(
   parameter int unsigned LEAK_SHIFT = 4
) (
   input  logic [VMEM_W-1:0] i_vmem,
   input  logic [VMEM_W-1:0] i_current,
   output logic [VMEM_W-1:0] o_v_next
);

   logic [VMEM_W-1:0] w_leaked;
   logic [VMEM_W:0]   w_sum;

   // Leak never underflows since vmem >> k <= vmem; the add is carried into bit 16.
   always_comb begin
      w_leaked = i_vmem - (i_vmem >> LEAK_SHIFT);
      w_sum    = {1'b0, w_leaked} + {1'b0, i_current};
      o_v_next = w_sum[VMEM_W] ? VMEM_MAX : w_sum[VMEM_W-1:0];
   end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with refractory period and saturating spike counter.
module lif_neuron
   import snn_pkg::*;
#(
   parameter logic [15:0] THRESHOLD     = 16'd1000,
   parameter int unsigned LEAK_SHIFT    = 4,
   parameter int unsigned REFRAC_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [VMEM_W-1:0] in_current,
   output logic              in_ready,
   output logic              spike,
   output logic [VMEM_W-1:0] vmem,
   output logic [VMEM_W-1:0] spike_count
);

   localparam logic [CNT_W-1:0] REFRAC_LOAD = CNT_W'(REFRAC_CYCLES);
   localparam bit               HAS_REFRAC  = (REFRAC_CYCLES != 0);

   lif_state_e        r_state;
   logic [CNT_W-1:0]  r_refrac_cnt;
   logic [VMEM_W-1:0] r_vmem;
   logic              r_spike;
   logic [VMEM_W-1:0] r_spike_count;

   lif_state_e        w_state_nx;
   logic [CNT_W-1:0]  w_refrac_cnt_nx;
   logic [VMEM_W-1:0] w_vmem_nx;
   logic              w_spike_nx;
   logic [VMEM_W-1:0] w_spike_count_nx;
   logic [VMEM_W-1:0] w_current_gated;
   logic [VMEM_W-1:0] w_v_next;

   assign in_ready        = (r_state == INTEG);
   assign w_current_gated = (in_valid && in_ready) ? in_current : '0;

   lif_leak_sat #(
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_leak_sat (
      .i_vmem    (r_vmem),
      .i_current (w_current_gated),
      .o_v_next  (w_v_next)
   );

   // Next-state and next-output decode.
   always_comb begin
      w_state_nx       = r_state;
      w_refrac_cnt_nx  = r_refrac_cnt;
      w_vmem_nx        = r_vmem;
      w_spike_nx       = 1'b0;
      w_spike_count_nx = r_spike_count;
      case (r_state)
         INTEG: begin
            if (w_v_next >= THRESHOLD) begin
               w_spike_nx       = 1'b1;
               w_vmem_nx        = '0;
               w_spike_count_nx = sat_inc(r_spike_count);
               if (HAS_REFRAC) begin
                  w_state_nx      = REFRAC;
                  w_refrac_cnt_nx = REFRAC_LOAD;
               end
            end else begin
               w_vmem_nx = w_v_next;
            end
         end
         REFRAC: begin
            w_vmem_nx       = '0;
            w_refrac_cnt_nx = r_refrac_cnt - CNT_W'(1);
            if (r_refrac_cnt <= CNT_W'(1)) begin
               w_state_nx = INTEG;
            end
         end
         default: begin
            w_state_nx = INTEG;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= INTEG;
         r_refrac_cnt  <= '0;
         r_vmem        <= '0;
         r_spike       <= 1'b0;
         r_spike_count <= '0;
      end else begin
         r_state       <= w_state_nx;
         r_refrac_cnt  <= w_refrac_cnt_nx;
         r_vmem        <= w_vmem_nx;
         r_spike       <= w_spike_nx;
         r_spike_count <= w_spike_count_nx;
      end
   end

   assign vmem        = r_vmem;
   assign spike       = r_spike;
   assign spike_count = r_spike_count;

endmodule
